// File: rtl/dram_axi_responder.sv
// AXI4-Lite DRAM model: one access at a time, register-array storage, fixed response latency.
// Define ADDR_CHECK_EN to return SLVERR for out-of-window or misaligned addresses.
module dram_axi_responder #(
  parameter int unsigned       ADDR_W  = 17,
  parameter int unsigned       DATA_W  = 64,
  parameter int unsigned       DEPTH   = 256,
  parameter logic [ADDR_W-1:0] BASE    = 17'h10000,
  parameter int unsigned       LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY
);

  localparam int unsigned IdxW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LatCnt     = 4'(LATENCY);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StRdWait, StRdResp, StWrData, StWrWait, StWrResp
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              r_valid_q, r_valid_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              b_valid_q, b_valid_d;
  logic [1:0]        b_resp_q, b_resp_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0] off;
  logic [IdxW-1:0]   idx;
  logic              addr_err;
  logic              unused_off;

  // Word index wraps within the array when the address is outside the window.
  assign off        = addr_q - BASE;
  assign idx        = off[IdxW+2:3];
  assign unused_off = ^{off[ADDR_W-1:IdxW+3], off[2:0]};

`ifdef ADDR_CHECK_EN
  logic [ADDR_W:0] lim;
  assign lim      = {1'b0, BASE} + (ADDR_W + 1)'(DEPTH * 8);
  assign addr_err = ({1'b0, addr_q} < {1'b0, BASE}) || ({1'b0, addr_q} >= lim) ||
                    (addr_q[2:0] != 3'b000);
`else
  assign addr_err = 1'b0;
`endif

  // READYs are gated by rst_n so every output reads 0 while reset is held.
  assign AR_READY = rst_n && (state_q == StIdle);
  assign AW_READY = rst_n && (state_q == StIdle) && !AR_VALID;
  assign W_READY  = rst_n && (state_q == StWrData);
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign B_VALID  = b_valid_q;
  assign B_RESP   = b_resp_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    mem_d     = mem_q;
    unique case (state_q)
      StIdle: begin
        if (AR_VALID) begin
          addr_d  = AR_ADDR;
          cnt_d   = 4'd1;
          state_d = StRdWait;
        end else if (AW_VALID) begin
          addr_d  = AW_ADDR;
          state_d = StWrData;
        end
      end
      StRdWait: begin
        if (cnt_q == LatCnt) begin
          cnt_d     = 4'd0;
          r_valid_d = 1'b1;
          r_data_d  = addr_err ? '0 : mem_q[idx];
          r_resp_d  = addr_err ? RespSlvErr : RespOkay;
          state_d   = StRdResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRdResp: begin
        if (R_READY) begin
          r_valid_d = 1'b0;
          r_data_d  = '0;
          r_resp_d  = RespOkay;
          state_d   = StIdle;
        end
      end
      StWrData: begin
        if (W_VALID) begin
          if (!addr_err) mem_d[idx] = W_DATA;
          cnt_d   = 4'd1;
          state_d = StWrWait;
        end
      end
      StWrWait: begin
        if (cnt_q == LatCnt) begin
          cnt_d     = 4'd0;
          b_valid_d = 1'b1;
          b_resp_d  = addr_err ? RespSlvErr : RespOkay;
          state_d   = StWrResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrResp: begin
        if (B_READY) begin
          b_valid_d = 1'b0;
          b_resp_d  = RespOkay;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_dram_axi_responder.sv
// Directed self-checking bench for dram_axi_responder (default parameters, LATENCY = 2).
module tb_dram_axi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA;
  logic [1:0]  R_RESP, B_RESP;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

  int errors = 0;
  int checks = 0;

  dram_axi_responder #(
    .ADDR_W (17),
    .DATA_W (64),
    .DEPTH  (256),
    .BASE   (17'h10000),
    .LATENCY(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .AR_VALID(AR_VALID),
    .AR_ADDR (AR_ADDR),
    .AR_READY(AR_READY),
    .R_VALID (R_VALID),
    .R_DATA  (R_DATA),
    .R_RESP  (R_RESP),
    .R_READY (R_READY),
    .AW_VALID(AW_VALID),
    .AW_ADDR (AW_ADDR),
    .AW_READY(AW_READY),
    .W_VALID (W_VALID),
    .W_DATA  (W_DATA),
    .W_READY (W_READY),
    .B_VALID (B_VALID),
    .B_RESP  (B_RESP),
    .B_READY (B_READY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ar_req(input logic [16:0] a);
    @(negedge clk);
    AR_VALID = 1'b1;
    AR_ADDR  = a;
    @(posedge clk);
    #1 AR_VALID = 1'b0;
  endtask

  task automatic aw_req(input logic [16:0] a);
    @(negedge clk);
    AW_VALID = 1'b1;
    AW_ADDR  = a;
    @(posedge clk);
    #1 AW_VALID = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d);
    @(negedge clk);
    W_VALID = 1'b1;
    W_DATA  = d;
    @(posedge clk);
    #1 W_VALID = 1'b0;
  endtask

  // Edges from the handshake to VALID, bounded at 20.
  task automatic wait_valid(input bit is_read, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!(is_read ? R_VALID : B_VALID) && n < 20);
  endtask

  task automatic r_accept();
    @(negedge clk);
    R_READY = 1'b1;
    @(posedge clk);
    #1 R_READY = 1'b0;
  endtask

  task automatic b_accept();
    @(negedge clk);
    B_READY = 1'b1;
    @(posedge clk);
    #1 B_READY = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [16:0] a, input logic [63:0] exp_d,
                         input logic [1:0] exp_r);
    int n;
    ar_req(a);
    wait_valid(1'b1, n);
    check({tag, "_lat"}, 128'(n), 128'd2);
    check({tag, "_data"}, 128'(R_DATA), 128'(exp_d));
    check({tag, "_resp"}, 128'(R_RESP), 128'(exp_r));
    r_accept();
    check({tag, "_rvalid_clr"}, 128'({R_VALID, R_DATA}), 128'd0);
  endtask

  task automatic do_write(input string tag, input logic [16:0] a, input logic [63:0] d,
                          input logic [1:0] exp_r);
    int n;
    aw_req(a);
    #1 check({tag, "_wready"}, 128'(W_READY), 128'd1);
    w_send(d);
    wait_valid(1'b0, n);
    check({tag, "_lat"}, 128'(n), 128'd2);
    check({tag, "_bresp"}, 128'(B_RESP), 128'(exp_r));
    b_accept();
    check({tag, "_bvalid_clr"}, 128'(B_VALID), 128'd0);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({AR_READY, AW_READY, W_READY, R_VALID, B_VALID, R_RESP, B_RESP, R_DATA});
  endfunction

  initial begin
    int n;
    int seen_b;
    rst_n = 1'b0;
    {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY} = '0;
    AR_ADDR = '0; AW_ADDR = '0; W_DATA = '0;
    #1 check("reset_outputs", all_outs(), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_readies", 128'({AR_READY, AW_READY, W_READY}), 128'b110);

    do_read("rd_empty", 17'h10000, 64'h0, 2'b00);
    check("ar_ready_after_r", 128'(AR_READY), 128'd1);

    do_write("wr_beef", 17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00);
    do_read("rd_beef", 17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00);

    // Simultaneous AR and AW: read goes first, AW is taken once back in IDLE.
    @(negedge clk);
    AR_VALID = 1'b1; AR_ADDR = 17'h10008;
    AW_VALID = 1'b1; AW_ADDR = 17'h10010;
    #1 check("both_ready", 128'({AR_READY, AW_READY}), 128'b10);
    @(posedge clk);
    #1 AR_VALID = 1'b0;
    check("both_aw_blocked", 128'({AR_READY, AW_READY}), 128'b00);
    wait_valid(1'b1, n);
    check("both_rd_data", 128'(R_DATA), 128'(64'hDEAD_BEEF_0123_4567));
    r_accept();
    check("both_aw_ready", 128'(AW_READY), 128'd1);
    @(posedge clk);
    #1 AW_VALID = 1'b0;
    check("both_w_ready", 128'(W_READY), 128'd1);
    w_send(64'h1111_2222_3333_4444);
    wait_valid(1'b0, n);
    check("both_b_lat", 128'(n), 128'd2);
    b_accept();
    do_read("rd_both", 17'h10010, 64'h1111_2222_3333_4444, 2'b00);

    // R_READY low for 5 cycles with a competing AR pending.
    ar_req(17'h10008);
    wait_valid(1'b1, n);
    AR_VALID = 1'b1; AR_ADDR = 17'h10000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("hold_r", 128'({AR_READY, R_VALID, R_RESP, R_DATA}),
               128'({1'b0, 1'b1, 2'b00, 64'hDEAD_BEEF_0123_4567}));
    end
    AR_VALID = 1'b0;
    r_accept();
    check("hold_release", 128'({R_VALID, AR_READY}), 128'b01);

`ifdef ADDR_CHECK_EN
    do_write("wr_low", 17'h0FFF8, 64'hCAFE_F00D_0000_0001, 2'b10);
    do_read("rd_wrapslot", 17'h107F8, 64'h0, 2'b00);
    do_read("rd_oob", 17'h10804, 64'h0, 2'b10);
    do_read("rd_misalign", 17'h1000C, 64'h0, 2'b10);
`else
    // Out-of-window write wraps to word 255; 0x1080C wraps to word 1.
    do_write("wr_low", 17'h0FFF8, 64'hCAFE_F00D_0000_0001, 2'b00);
    do_read("rd_wrapslot", 17'h107F8, 64'hCAFE_F00D_0000_0001, 2'b00);
    do_read("rd_oob", 17'h1080C, 64'hDEAD_BEEF_0123_4567, 2'b00);
    do_read("rd_misalign", 17'h1000C, 64'hDEAD_BEEF_0123_4567, 2'b00);
`endif

    // Reset during WR_WAIT aborts the write and clears memory.
    aw_req(17'h10018);
    w_send(64'hAAAA_5555_AAAA_5555);
    #1 rst_n = 1'b0;
    #1 check("rst_outputs", all_outs(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    B_READY = 1'b1;
    seen_b = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 if (B_VALID) seen_b++;
    end
    B_READY = 1'b0;
    check("rst_no_b", 128'(seen_b), 128'd0);
    do_read("rd_after_rst", 17'h10018, 64'h0, 2'b00);
    do_read("rd_cleared", 17'h10008, 64'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
